// File: rtl/serial_sub_16bit_pkg.sv
// ============================================================================
// Module      : serial_sub_16bit_pkg
// Description : Shared state encodings and default sizing for the bit-serial
//               subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_16bit_pkg;

    // Controller states; the encodings are fixed so they can be read from a debug bus.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Default operand width and bit-counter width (2**CNT_W must exceed WIDTH).
    localparam int c_DEF_WIDTH = 16;
    localparam int c_DEF_CNT_W = 5;

endpackage

`default_nettype wire

// File: rtl/serial_sub_16bit_cell.sv
// ============================================================================
// Module      : full_sub_cell
// Description : One-bit full subtractor (d = a - b - bin) assembled from
//               XOR and NAND cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_x;
    logic w_n1;
    logic w_n2;

    // Difference bit: two cascaded XOR cells.
    assign w_x  = a ^ b;
    assign d    = w_x ^ bin;

    // Borrow: (~a & b) | (~(a^b) & bin) expressed as NAND-of-NANDs.
    assign w_n1 = ~((~a) & b);
    assign w_n2 = ~((~w_x) & bin);
    assign bout = ~(w_n1 & w_n2);

endmodule

`default_nettype wire

// File: rtl/serial_sub_16bit.sv
// ============================================================================
// Module      : serial_sub_16bit
// Description : Bit-serial two's-complement subtractor, diff = a - b, one bit
//               per clock LSB first, with start/done handshake and
//               borrow/overflow/zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_16bit
    import serial_sub_16bit_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int CNT_W = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             zero
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-2:0]   r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;

    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;
    logic               r_ovf;
    logic               r_zero;

    logic               w_d;
    logic               w_bn;
    logic [WIDTH-1:0]   w_res_final;

    // Single serial subtractor cell working on the current LSBs.
    full_sub_cell u_cell (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bn)
    );

    assign w_last      = (r_cnt == c_LAST);
    // The final difference bit enters at the MSB alongside the bits already shifted in.
    assign w_res_final = {w_d, r_res};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and accept decode; start is only honoured outside RUN.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting, borrow chain and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_accept) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
            r_res    <= w_res_final[WIDTH-1:1];
            r_borrow <= w_bn;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Result and flags are updated only on the last serial step so partial sums never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_ovf        <= 1'b0;
            r_zero       <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_diff       <= w_res_final;
            r_borrow_out <= w_bn;
            r_ovf        <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
            r_zero       <= (w_res_final == '0);
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign ovf        = r_ovf;
    assign zero       = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_16bit.sv
// ============================================================================
// Module      : tb_serial_sub_16bit
// Description : Self-checking bench for serial_sub_16bit using an expected-
//               result queue filled on accept and drained on done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub_16bit;

    localparam int c_W = 16;

    typedef struct {
        logic [c_W-1:0] diff;
        logic           borrow;
        logic           ovf;
        logic           zero;
        int             due;
        string          tag;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] diff;
    logic           borrow_out;
    logic           ovf;
    logic           zero;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    serial_sub_16bit #(.WIDTH(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [c_W-1:0] x, input logic [c_W-1:0] y,
                                   input int due, input string tag);
        exp_t e;
        e.diff   = x - y;
        e.borrow = (x < y);
        e.ovf    = (x[c_W-1] ^ y[c_W-1]) & (x[c_W-1] ^ e.diff[c_W-1]);
        e.zero   = (e.diff == '0);
        e.due    = due;
        e.tag    = tag;
        return e;
    endfunction

    // Scoreboard: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_diff"},   32'(diff),       32'(e.diff));
                check({e.tag, "_borrow"}, 32'(borrow_out), 32'(e.borrow));
                check({e.tag, "_ovf"},    32'(ovf),        32'(e.ovf));
                check({e.tag, "_zero"},   32'(zero),       32'(e.zero));
                check({e.tag, "_done_cycle"}, 32'(cyc),    32'(e.due));
                check({e.tag, "_busy_in_done"}, 32'(busy), 32'd0);
            end
        end
    end

    // Issue one operation as soon as the DUT can accept it (IDLE or DONE).
    task automatic issue(input logic [c_W-1:0] x, input logic [c_W-1:0] y, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, "_accept_timeout"}, 32'(busy), 32'd0);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(x, y, cyc + c_W, tag));
        start = 1'b0;
    endtask

    // Wait (bounded) until every queued result has been retired.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_drain_remaining"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [c_W-1:0] ra;
        logic [c_W-1:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_diff",   32'(diff),       32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_ovf",    32'(ovf),        32'd0);
        check("rst_zero",   32'(zero),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with a gap between them.
        issue(16'h0005, 16'h0003, "t1_5m3");     drain("t1");
        issue(16'h0003, 16'h0005, "t2_3m5");     drain("t2a");
        issue(16'h1234, 16'h1234, "t2_eq");      drain("t2b");
        issue(16'h8000, 16'h0001, "t3_minm1");   drain("t3a");
        issue(16'h7FFF, 16'hFFFF, "t3_maxmm1");  drain("t3b");

        // Start held high through a run while operands toggle, then back-to-back accept in DONE.
        @(negedge clk);
        a     = 16'hA5A5;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(16'hA5A5, 16'h1111, cyc + c_W, "t4_first"));
        for (int i = 0; i < c_W; i++) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom);
            if (i == 3) check("t4_busy_mid", 32'(busy), 32'd1);
        end
        @(negedge clk);
        a = 16'h0100;
        b = 16'h0200;
        @(posedge clk);
        #1;
        sb.push_back(model(16'h0100, 16'h0200, cyc + c_W, "t4_b2b"));
        start = 1'b0;
        drain("t4");

        // Asynchronous reset in the middle of a run aborts it with no done pulse.
        @(negedge clk);
        a     = 16'h4321;
        b     = 16'h0FFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy),       32'd0);
        check("t5_rst_done", 32'(done),       32'd0);
        check("t5_rst_diff", 32'(diff),       32'd0);
        check("t5_rst_flag", 32'({borrow_out, ovf, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(16'h4321, 16'h0FFF, "t5_after");   drain("t5");

        // Random pairs, issued back-to-back whenever the DUT can accept.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 50 == 0) rb = ra;
            issue(ra, rb, "t6_rand");
        end
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
